// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after d[7].
package uart_pkg;

    localparam int   UART_DATA_W     = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Transmitter frame states; PARITY exists only in the parity build.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } uart_state_e;

    // Even parity: XOR of all data bits, so the frame carries an even count of ones.
    function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr,
// wrapping modulo NREQ. The pointer register lives in the parent.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic           found_s;
    logic           take_s;
    logic [IDW-1:0] idx_s;

    // Scan requesters starting at ptr; the first active one wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        take_s  = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s      = IDW'((int'(ptr) + k) % NREQ);
            take_s     = req[idx_s] & ~found_s;
            found_s    = found_s | take_s;
            gnt[idx_s] = take_s;
            gnt_id     = gnt_id | (take_s ? idx_s : '0);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: accepts one byte at a time from NREQ
// requesters and serialises it LSB first, one bit per baud_tick.
// Build option: define UART_TX_PARITY_EN for 8E1/8E2 frames (default 8N1/8N2).
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int STOP_BITS = 1,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        baud_tick,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [IDW-1:0]              grant_id
);

    uart_state_e            state_r, state_nx_s;
    logic                   tx_r, tx_nx_s;
    logic [UART_DATA_W-1:0] data_r, data_nx_s;
    logic [3:0]             bit_cnt_r, bit_cnt_nx_s;
    logic [1:0]             stop_cnt_r, stop_cnt_nx_s;
    logic [IDW-1:0]         ptr_r, ptr_nx_s;
    logic [IDW-1:0]         grant_r, grant_nx_s;

    logic [NREQ-1:0]        arb_gnt_s;
    logic [IDW-1:0]         arb_id_s;
    logic                   accept_s;
    logic [UART_DATA_W-1:0] sel_data_s;
    logic [IDW-1:0]         ptr_wrap_s;

    uart_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_r),
        .gnt    (arb_gnt_s),
        .gnt_id (arb_id_s)
    );

    // The arbiter only grants valid requesters, so any grant in IDLE is a transfer.
    assign accept_s   = (state_r == ST_IDLE) && (|arb_gnt_s);
    assign req_ready  = (state_r == ST_IDLE) ? arb_gnt_s : '0;
    assign sel_data_s = req_data[{arb_id_s, 3'b000} +: UART_DATA_W];
    assign ptr_wrap_s = (arb_id_s == IDW'(NREQ - 1)) ? '0 : (arb_id_s + IDW'(1));

    assign tx       = tx_r;
    assign busy     = (state_r != ST_IDLE);
    assign grant_id = grant_r;

    // Next-state and next-output logic; every bit advance is gated by baud_tick.
    always_comb begin
        state_nx_s    = state_r;
        tx_nx_s       = tx_r;
        data_nx_s     = data_r;
        bit_cnt_nx_s  = bit_cnt_r;
        stop_cnt_nx_s = stop_cnt_r;
        ptr_nx_s      = ptr_r;
        grant_nx_s    = grant_r;
        case (state_r)
            ST_IDLE: begin
                // baud_tick is deliberately ignored here, even in the accept cycle.
                tx_nx_s = UART_IDLE_LEVEL;
                if (accept_s) begin
                    data_nx_s  = sel_data_s;
                    grant_nx_s = arb_id_s;
                    ptr_nx_s   = ptr_wrap_s;
                    state_nx_s = ST_SYNC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (baud_tick) begin
                    tx_nx_s    = 1'b0;
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_SYNC;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_nx_s      = data_r[0];
                    bit_cnt_nx_s = 4'd1;
                    state_nx_s   = ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_r < 4'd8) begin
                        tx_nx_s      = data_r[bit_cnt_r[2:0]];
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_nx_s    = uart_even_parity(data_r);
                        state_nx_s = ST_PARITY;
`else
                        tx_nx_s       = UART_IDLE_LEVEL;
                        stop_cnt_nx_s = 2'd0;
                        state_nx_s    = ST_STOP;
`endif
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_nx_s       = UART_IDLE_LEVEL;
                    stop_cnt_nx_s = 2'd0;
                    state_nx_s    = ST_STOP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                tx_nx_s = UART_IDLE_LEVEL;
                if (baud_tick) begin
                    if (stop_cnt_r == 2'(STOP_BITS - 1)) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        stop_cnt_nx_s = stop_cnt_r + 2'd1;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                tx_nx_s    = UART_IDLE_LEVEL;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any frame and returns the line to mark.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_r       <= UART_IDLE_LEVEL;
            data_r     <= '0;
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 2'd0;
            ptr_r      <= '0;
            grant_r    <= '0;
        end else begin
            state_r    <= state_nx_s;
            tx_r       <= tx_nx_s;
            data_r     <= data_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            stop_cnt_r <= stop_cnt_nx_s;
            ptr_r      <= ptr_nx_s;
            grant_r    <= grant_nx_s;
        end
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit line between `NREQ` byte requesters. The block accepts one byte at a time over a valid/ready handshake and serialises it as an 8N1 frame (optionally 8E1), one bit per baud period. It sits between client logic and the pin, clocked by `sys_clk`. Its bit timing comes from a one-cycle `baud_tick` pulse produced by the team's baud generator at `BAUDRATE`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  one-cycle pulse marking each baud-period boundary.
- `req_valid`  in  NREQ  requester i has a byte pending.
- `req_data`  in  8*NREQ  requester i's byte on `[8i+7:8i]`.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `tx`  out  1  serial line; idles at 1.
- `busy`  out  1  a frame is in progress.
- `grant_id`  out  clog2(NREQ)  index of the most recently accepted requester.

## Operation
- States: IDLE, SYNC, START, DATA, PARITY (only when the parity build is enabled), STOP.
- **IDLE**
  - The arbiter picks the first requester with `req_valid` high, searching upward from `ptr` and wrapping modulo `NREQ`.
  - `req_ready[winner]` is driven combinationally high; all other ready bits are 0.
  - Transfer happens in a cycle where valid and ready are both high.
  - On transfer: latch the byte into the shift register, set `grant_id` and `ptr` to winner+1 mod `NREQ`, and go to SYNC.
  - `req_ready` is 0 in every state other than IDLE.
- **SYNC**: on `baud_tick`, `tx`<=0 (start bit) and go to START.
- **START**: on `baud_tick`, `tx`<=d[0], `bit_cnt`<=1, go to DATA.
- **DATA**: on `baud_tick`:
  - if `bit_cnt`<8: `tx`<=d[`bit_cnt`] and increment `bit_cnt`;
  - else: go to PARITY, driving `tx` to the even-parity bit (parity build), or go to STOP driving `tx`<=1 (non-parity build).
- **PARITY**: on `baud_tick`, `tx`<=1 and go to STOP.
- **STOP**: count `STOP_BITS` ticks, then go to IDLE with `tx` held at 1.
- Data is sent LSB first. Each bit is held for exactly one tick-to-tick interval.
- `baud_tick` has no edge detection: every cycle in which it is high advances one bit.
- `baud_tick` is ignored in IDLE, including in the accept cycle.
- A requester may drop `req_valid` before it is granted; no state is kept for requesters that were not accepted. A requester must hold its data stable while `req_valid` is high.
- `busy` = (state != IDLE).

## Timing
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `ptr`=0, state IDLE. Requester 0 therefore has highest priority after reset.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously, the byte is discarded and the arbiter pointer resets.
- Start-bit latency: `tx` falls one cycle after the first `baud_tick` that follows the accept cycle.
- Frame length: 1 + 8 + P + `STOP_BITS` baud periods, where P=1 in the parity build and 0 otherwise.
- Back-to-back frames: the next accept can occur no earlier than the cycle after the final STOP tick. The line then stays idle until the next tick, so consecutive frames are separated by at least one extra mark period.
- Simultaneous requests: exactly one grant per frame. With all requesters permanently valid, grant order is strictly 0,1,…,NREQ-1,0.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and an even-parity bit (XOR of the data bits) is sent after d[7]. Frames are 8E1/8E2.
- Undefined: the PARITY state and its logic are absent; DATA goes straight to STOP. Frames are 8N1/8N2.

## Structure
- Shared package `uart_pkg`:
  - state enum;
  - `UART_DATA_W`=8;
  - `UART_IDLE_LEVEL`=1'b1.
- Sub-module `uart_rr_arbiter`: combinational round-robin arbiter.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt` and binary `gnt_id`.
  - `ptr` is kept in the parent.

## Test plan
- Requester 2 sends 0x55 with `baud_tick` every 16 cycles.
  - `tx` = 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles.
  - `grant_id`=2; `busy` high for 10 periods.
- Requesters 0 and 1 are valid in the same cycle after reset.
  - Requester 0 is accepted first (`req_ready`=4'b0001), then requester 1 after the frame.
- All four requesters continuously valid for 5 frames.
  - Grant order 0,1,2,3,0; `req_ready` is never multi-hot.
- `rst` pulsed during data bit 4 of byte 0x00.
  - `tx`=1 in the same cycle; `busy`=0; `grant_id`=0.
  - The next request from requester 3 starts a clean frame.
- Parity build, byte 0x07: the bit after d[7] is 1.
  - Byte 0x03 in the same build: that bit is 0.
- `baud_tick` high during the accept cycle.
  - It is ignored; the start bit begins only after the next tick.
